// File: rtl/cache_mem_arbiter.sv
// Memory-port arbiter between the read-only instruction cache and the
// write-through data cache. One request is granted at a time and held on the
// m_* port until the memory answers. The data side normally wins, but a
// starvation counter forces an instruction grant after STARVE_MAX consecutive
// data grants made while the instruction side was waiting.
module cache_mem_arbiter #(
    parameter int A_WIDTH    = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic               i_strobe,
    input  logic [A_WIDTH-1:0] i_a,
    output logic               i_ready,
    output logic [31:0]        i_dout,
    input  logic               d_strobe,
    input  logic               d_rw,
    input  logic [A_WIDTH-1:0] d_a,
    input  logic [31:0]        d_din,
    output logic               d_ready,
    output logic [31:0]        d_dout,
    input  logic               flush,
    output logic               m_strobe,
    output logic               m_rw,
    output logic [A_WIDTH-1:0] m_a,
    output logic [31:0]        m_din,
    input  logic [31:0]        m_dout,
    input  logic               m_ready,
    output logic [1:0]         gnt
);

    localparam int DATA_W = 32;

    // Counter is 4 bits wide, enough for the largest allowed limit of 15.
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] starve_cnt;
    logic       d_req;
    logic       d_win;

    // Saturating increment of the starvation counter.
    function automatic logic [3:0] starve_inc(input logic [3:0] c);
        return (c >= STARVE_LIM) ? c : c + 4'd1;
    endfunction

    // Grant decision for the IDLE state: flush masks new data requests, and
    // the data side loses only when the instruction side has waited too long.
    always_comb begin
        d_req = d_strobe & ~flush;
        d_win = d_req & (~i_strobe | (starve_cnt < STARVE_LIM));
    end

    // Arbitration FSM; the memory-side request is registered at grant time
    // and held unchanged until memory signals completion.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state      <= IDLE;
            starve_cnt <= '0;
            m_strobe   <= 1'b0;
            m_rw       <= 1'b0;
            m_a        <= '0;
            m_din      <= '0;
            gnt        <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (d_win) begin
                        state      <= SERVE_D;
                        m_strobe   <= 1'b1;
                        m_rw       <= d_rw;
                        m_a        <= d_a;
                        m_din      <= d_din;
                        gnt        <= 2'b10;
                        starve_cnt <= i_strobe ? starve_inc(starve_cnt) : 4'd0;
                    end else if (i_strobe) begin
                        state      <= SERVE_I;
                        m_strobe   <= 1'b1;
                        m_rw       <= 1'b0;
                        m_a        <= i_a;
                        m_din      <= '0;
                        gnt        <= 2'b01;
                        starve_cnt <= 4'd0;
                    end else begin
                        starve_cnt <= 4'd0;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (m_ready) begin
                        state    <= IDLE;
                        m_strobe <= 1'b0;
                        gnt      <= 2'b00;
                    end
                end
                default: begin
                    state    <= IDLE;
                    m_strobe <= 1'b0;
                    gnt      <= 2'b00;
                end
            endcase
        end
    end

    // Completion is steered back to whichever side owns the port; read data
    // passes straight through and is qualified by the matching ready.
    always_comb begin
        i_ready = (state == SERVE_I) & m_ready;
        d_ready = (state == SERVE_D) & m_ready;
        i_dout  = m_dout[DATA_W-1:0];
        d_dout  = m_dout[DATA_W-1:0];
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Testbench for cache_mem_arbiter: directed scenarios followed by random
// traffic, all compared against a transaction-level ownership model.
module tb_cache_mem_arbiter;

    localparam int AW   = 32;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          clrn;
    logic          i_strobe;
    logic [AW-1:0] i_a;
    logic          i_ready;
    logic [31:0]   i_dout;
    logic          d_strobe;
    logic          d_rw;
    logic [AW-1:0] d_a;
    logic [31:0]   d_din;
    logic          d_ready;
    logic [31:0]   d_dout;
    logic          flush;
    logic          m_strobe;
    logic          m_rw;
    logic [AW-1:0] m_a;
    logic [31:0]   m_din;
    logic [31:0]   m_dout;
    logic          m_ready;
    logic [1:0]    gnt;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: who owns the memory port (0 nobody, 1 I, 2 D), how many
    // data grants the waiting I side has sat through, and the granted request.
    int          own;
    int          dwins;
    logic [31:0] ea;
    logic        erw;
    logic [31:0] edin;

    logic [1:0] seq [6];
    logic [1:0] seq_exp [6];

    cache_mem_arbiter #(.A_WIDTH(AW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .clrn(clrn),
        .i_strobe(i_strobe), .i_a(i_a), .i_ready(i_ready), .i_dout(i_dout),
        .d_strobe(d_strobe), .d_rw(d_rw), .d_a(d_a), .d_din(d_din),
        .d_ready(d_ready), .d_dout(d_dout), .flush(flush),
        .m_strobe(m_strobe), .m_rw(m_rw), .m_a(m_a), .m_din(m_din),
        .m_dout(m_dout), .m_ready(m_ready), .gnt(gnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        own   = 0;
        dwins = 0;
        ea    = '0;
        erw   = 1'b0;
        edin  = '0;
    endtask

    // One clock cycle with the inputs already applied: checks the completion
    // outputs before the edge, advances the model, checks the port after it.
    task automatic cycle();
        logic [1:0] eg;
        #1;
        chk("i_ready", 32'(i_ready), 32'(own == 1 && m_ready));
        chk("d_ready", 32'(d_ready), 32'(own == 2 && m_ready));
        chk("i_dout", i_dout, m_dout);
        chk("d_dout", d_dout, m_dout);
        if (own == 0) begin
            if (d_strobe && !flush && (!i_strobe || dwins < SMAX)) begin
                own  = 2;
                ea   = d_a;
                erw  = d_rw;
                edin = d_din;
                if (i_strobe) dwins = (dwins < SMAX) ? dwins + 1 : dwins;
                else          dwins = 0;
            end else if (i_strobe) begin
                own   = 1;
                ea    = i_a;
                erw   = 1'b0;
                edin  = '0;
                dwins = 0;
            end else begin
                dwins = 0;
            end
        end else if (m_ready) begin
            own = 0;
        end
        @(posedge clk);
        #1;
        eg = (own == 1) ? 2'b01 : (own == 2) ? 2'b10 : 2'b00;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("m_strobe", 32'(m_strobe), 32'(own != 0));
        if (own != 0) begin
            chk("m_a", m_a, ea);
            chk("m_rw", 32'(m_rw), 32'(erw));
            chk("m_din", m_din, edin);
        end
    endtask

    task automatic quiet();
        i_strobe = 1'b0;
        d_strobe = 1'b0;
        flush    = 1'b0;
        m_ready  = 1'b0;
    endtask

    initial begin
        clrn = 1'b0;
        quiet();
        i_a = '0; d_a = '0; d_rw = 1'b0; d_din = '0; m_dout = '0;
        model_reset();
        seq_exp = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};

        // Reset state
        #12;
        chk("rst_m_strobe", 32'(m_strobe), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_m_a", m_a, 32'd0);
        chk("rst_m_din", m_din, 32'd0);
        chk("rst_m_rw", 32'(m_rw), 32'd0);
        chk("rst_i_ready", 32'(i_ready), 32'd0);
        chk("rst_d_ready", 32'(d_ready), 32'd0);
        @(posedge clk); #1;
        clrn = 1'b1;
        cycle();

        // I-only fetch with memory answering three cycles after the request
        i_strobe = 1'b1; i_a = 32'hBFC0_0000;
        cycle();
        chk("t1_m_a", m_a, 32'hBFC0_0000);
        chk("t1_gnt", 32'(gnt), 32'd1);
        cycle(); cycle();
        m_ready = 1'b1; m_dout = 32'h2408_0001;
        #1;
        chk("t1_i_ready", 32'(i_ready), 32'd1);
        chk("t1_i_dout", i_dout, 32'h2408_0001);
        cycle();
        quiet();
        cycle();

        // D write
        d_strobe = 1'b1; d_rw = 1'b1; d_a = 32'h1FAF_0000; d_din = 32'hDEAD_BEEF;
        cycle();
        chk("t2_m_rw", 32'(m_rw), 32'd1);
        chk("t2_m_din", m_din, 32'hDEAD_BEEF);
        chk("t2_gnt", 32'(gnt), 32'd2);
        m_ready = 1'b1;
        #1;
        chk("t2_d_ready", 32'(d_ready), 32'd1);
        chk("t2_i_ready", 32'(i_ready), 32'd0);
        cycle();
        quiet();
        cycle();

        // Simultaneous requests: data first, one idle cycle, then instruction
        i_strobe = 1'b1; i_a = 32'h0000_1000;
        d_strobe = 1'b1; d_rw = 1'b0; d_a = 32'h0000_2000;
        cycle();
        chk("t3_gnt_d", 32'(gnt), 32'd2);
        m_ready = 1'b1;
        cycle();
        chk("t3_gnt_idle", 32'(gnt), 32'd0);
        d_strobe = 1'b0; m_ready = 1'b0;
        cycle();
        chk("t3_gnt_i", 32'(gnt), 32'd1);
        m_ready = 1'b1;
        cycle();
        quiet();
        cycle();

        // Starvation limit with both sides requesting continuously
        i_strobe = 1'b1; d_strobe = 1'b1; d_rw = 1'b1;
        for (int k = 0; k < 6; k++) begin
            d_a = 32'h0001_0000 + 32'(k); d_din = $urandom;
            m_ready = 1'b0;
            cycle();
            seq[k] = gnt;
            m_ready = 1'b1;
            cycle();
        end
        for (int k = 0; k < 6; k++) chk($sformatf("t4_grant%0d", k), 32'(seq[k]), 32'(seq_exp[k]));
        quiet();
        cycle();

        // flush blocks a new data grant but not one already running
        flush = 1'b1; d_strobe = 1'b1; i_strobe = 1'b1; i_a = 32'h0000_3000;
        cycle();
        chk("t5_gnt_i", 32'(gnt), 32'd1);
        m_ready = 1'b1;
        cycle();
        i_strobe = 1'b0; flush = 1'b0; m_ready = 1'b0;
        cycle();
        chk("t5_gnt_d", 32'(gnt), 32'd2);
        flush = 1'b1;
        cycle();
        m_ready = 1'b1;
        #1;
        chk("t5_d_ready", 32'(d_ready), 32'd1);
        cycle();
        quiet();
        cycle();

        // Reset in the middle of a data transaction
        d_strobe = 1'b1; d_rw = 1'b1; d_a = 32'h0000_4000; d_din = 32'h1234_5678;
        cycle();
        clrn = 1'b0; m_ready = 1'b1;
        #1;
        chk("t6_m_strobe", 32'(m_strobe), 32'd0);
        chk("t6_gnt", 32'(gnt), 32'd0);
        chk("t6_d_ready", 32'(d_ready), 32'd0);
        model_reset();
        @(posedge clk); #1;
        m_ready = 1'b0;
        clrn = 1'b1;
        cycle();
        chk("t6_regrant", 32'(gnt), 32'd2);
        chk("t6_m_a", m_a, 32'h0000_4000);
        m_ready = 1'b1;
        cycle();
        quiet();
        cycle();

        // Random traffic: strobes may drop at any time, memory may answer
        // at any time including while the port is idle
        for (int n = 0; n < 600; n++) begin
            i_strobe = ($urandom_range(0, 3) != 0);
            d_strobe = ($urandom_range(0, 4) != 0);
            d_rw     = $urandom_range(0, 1) == 1;
            flush    = ($urandom_range(0, 9) == 0);
            i_a      = $urandom;
            d_a      = $urandom;
            d_din    = $urandom;
            m_dout   = $urandom;
            m_ready  = ($urandom_range(0, 2) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
